alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage directly downstream of the ALU register bank. Consumes the packed
//  operand byte from the bank: upper nibble = A, lower nibble = B.
//  Runs single-cycle logic/arith ops and multi-cycle shift-add multiply and
//  restoring divide. Holds each result behind a valid/ready handshake until the
//  writeback consumer takes it.
// PARAMETERS
//  DATA_W  4  operand width; operand bus and result are 2*DATA_W
//  OP_W    3  opcode width
// PORTS
//  clk        in   1         single clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         operand/opcode presented
//  in_ready   out  1         unit can accept (high only in IDLE)
//  operands   in   2*DATA_W  {A,B}: A=[2*DATA_W-1:DATA_W], B=[DATA_W-1:0]
//  opcode     in   OP_W      operation select, captured at accept
//  res_valid  out  1         result/flags valid and held stable
//  res_ready  in   1         consumer takes result
//  result     out  2*DATA_W  result word
//  flag_zero  out  1         result == 0
//  flag_carry out  1         ADD carry-out / SUB borrow; 0 for other ops
//  flag_err   out  1         divide-by-zero or illegal opcode
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1 (from the cycle after reset deasserts);
//    res_valid=0, result=0, all flags=0, iteration counter=0. While rst is high,
//    in_ready=0.
//  - Accept: edge where in_valid && in_ready; A, B and opcode are captured.
//    Inputs are ignored outside IDLE.
//  - FSM: IDLE -> DONE (single-cycle ops); IDLE -> CALC (MUL/DIV).
//    CALC -> DONE after DATA_W iterations.
//    DONE -> IDLE on the edge where res_ready=1.
//  - Latency: single-cycle ops assert res_valid on the edge after accept.
//    MUL/DIV assert res_valid DATA_W+1 edges after accept.
//  - res_valid holds until res_ready. result/flags do not change while res_valid=1.
//  - Throughput: DONE->IDLE costs one cycle, so back-to-back accepts are at least
//    2 cycles apart.
//  - Opcodes (results zero-extended to 2*DATA_W unless stated):
//    000 ADD  result=A+B, DATA_W+1 bits; carry = bit DATA_W
//    001 SUB  result[DATA_W-1:0]=A-B mod 2^DATA_W; carry=(A<B); upper bits 0
//    010 AND, 011 OR, 100 XOR  bitwise on A,B; carry=0
//    101 SWAP result={B,A}
//    110 MUL  unsigned A*B, full 2*DATA_W product.
//             Iterative shift-add, one multiplier bit per CALC cycle.
//    111 DIV  see CONFIGURATION
//  - flag_zero computed on the final 2*DATA_W result. All flags register with result.
//  - Counter counts 0..DATA_W-1 in CALC; wraps to 0 on exit to DONE.
//  - rst mid-CALC or in DONE aborts the operation. The pending result is discarded;
//    the reset values above apply on the next edge.
//  - in_valid during CALC/DONE has no effect; the upstream bank holds its data.
// CONFIGURATION
//  ALU_DIV_EN defined:
//    - 111 = unsigned restoring divide, one quotient bit per CALC cycle.
//    - result = {remainder, quotient}.
//    - B==0: quotient = all ones, remainder = A, flag_err=1; full DATA_W-cycle
//      latency kept.
//  ALU_DIV_EN undefined:
//    - 111 is illegal: single-cycle, result=0, flag_zero=1, flag_err=1.
//    - No divider logic is synthesised.
// TESTING
//  1. rst=1 for 2 cycles, then release -> res_valid=0, result=8'h00, flags=0;
//     in_ready=1 on the first edge after release.
//  2. ADD A=9 B=8, res_ready=1 -> next edge result=8'h11, carry=1, zero=0;
//     in_ready=1 again one cycle later.
//  3. SUB A=3 B=5 -> result=8'h0E, carry=1.
//     Then XOR A=B=6 -> result=8'h00, zero=1.
//  4. MUL A=15 B=15 -> in_ready=0 for 4 CALC cycles; result=8'hE1 with
//     res_valid on the 5th edge after accept. Hold res_ready=0 3 cycles ->
//     result stable, no new accept.
//  5. DIV A=13 B=4 (ALU_DIV_EN) -> result={4'h1,4'h3}.
//     DIV A=7 B=0 -> result=8'h7F, flag_err=1.
//     Without the macro: result=8'h00, err=1, zero=1.
//  6. Start MUL, assert rst on 2nd CALC cycle -> state IDLE, res_valid never
//     asserted for that op. Next ADD 1+1 -> result=8'h02.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Operand/opcode request channel and result/flag response channel of alu_exec_unit.
// The master is the upstream bank plus writeback consumer; the slave is the execute unit.
interface alu_exec_unit_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned OP_W   = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   operands;
    logic [OP_W-1:0]       opcode;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*DATA_W-1:0]   result;
    logic                  flag_zero;
    logic                  flag_carry;
    logic                  flag_err;

    modport master (
        output in_valid, operands, opcode, res_ready,
        input  in_ready, res_valid, result, flag_zero, flag_carry, flag_err
    );

    modport slave (
        input  in_valid, operands, opcode, res_ready,
        output in_ready, res_valid, result, flag_zero, flag_carry, flag_err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arith ops, iterative shift-add multiply and optional
// restoring divide (enabled by defining ALU_DIV_EN), result held behind valid/ready.
module alu_exec_unit #(
    parameter int unsigned DATA_W = 4,  // must be >= 2
    parameter int unsigned OP_W   = 3
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(2);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(3);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(4);
    localparam logic [OP_W-1:0] OpSwap = OP_W'(5);
    localparam logic [OP_W-1:0] OpMul  = OP_W'(6);
    localparam logic [OP_W-1:0] OpDiv  = OP_W'(7);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] a_q, b_q;
    logic [RES_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RES_W-1:0]  result_q;
    logic              zero_q, carry_q, err_q;

    logic              accept;
    logic              multi_in;
    logic              last_iter;
    logic [DATA_W-1:0] a_in, b_in;

    assign a_in      = bus.operands[RES_W-1:DATA_W];
    assign b_in      = bus.operands[DATA_W-1:0];
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef ALU_DIV_EN
    logic div_q;
    assign multi_in = (bus.opcode == OpMul) || (bus.opcode == OpDiv);
`else
    assign multi_in = (bus.opcode == OpMul);
`endif

    // ---------------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = multi_in ? StCalc : StDone;
            StCalc:  if (last_iter) state_d = StDone;
            StDone:  if (bus.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            StIdle:  bus.in_ready  = !rst;
            StDone:  bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_err   = err_q;

    // ---------------------------------------------------------------------------------
    // Single-cycle operations, evaluated straight from the bus at accept
    // ---------------------------------------------------------------------------------
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic [RES_W-1:0]  sc_res;
    logic              sc_carry, sc_err;

    always_comb begin
        sum      = {1'b0, a_in} + {1'b0, b_in};
        diff     = a_in - b_in;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (bus.opcode)
            OpAdd: begin
                sc_res   = RES_W'(sum);
                sc_carry = sum[DATA_W];
            end
            OpSub: begin
                sc_res   = RES_W'(diff);
                sc_carry = (a_in < b_in);
            end
            OpAnd:  sc_res = RES_W'(a_in & b_in);
            OpOr:   sc_res = RES_W'(a_in | b_in);
            OpXor:  sc_res = RES_W'(a_in ^ b_in);
            OpSwap: sc_res = {b_in, a_in};
            OpMul:  ;
            // Without the divider, DIV lands here as an illegal opcode.
            default: sc_err = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Iterative step: one multiplier bit or one quotient bit per CALC cycle
    // ---------------------------------------------------------------------------------
    logic [RES_W-1:0] mul_acc;
    logic [RES_W-1:0] acc_d;
    logic [RES_W-1:0] calc_res;
    logic             calc_err;

    assign mul_acc = acc_q + (b_q[cnt_q] ? (RES_W'(a_q) << cnt_q) : '0);

`ifdef ALU_DIV_EN
    // acc_q holds {quotient, remainder} while dividing; quotient bits shift in at the LSB.
    logic [CNT_W-1:0]  div_idx;
    logic [DATA_W:0]   rem_sh;
    logic              div_ge;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quot_nx;

    always_comb begin
        div_idx = CNT_W'(DATA_W - 1) - cnt_q;
        rem_sh  = {acc_q[DATA_W-1:0], a_q[div_idx]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        rem_nx  = div_ge ? DATA_W'(rem_sh - {1'b0, b_q}) : rem_sh[DATA_W-1:0];
        quot_nx = {acc_q[RES_W-2:DATA_W], div_ge};
        if (div_q) begin
            acc_d    = {quot_nx, rem_nx};
            calc_res = {rem_nx, quot_nx};
            calc_err = (b_q == '0);
        end else begin
            acc_d    = mul_acc;
            calc_res = mul_acc;
            calc_err = 1'b0;
        end
    end
`else
    always_comb begin
        acc_d    = mul_acc;
        calc_res = mul_acc;
        calc_err = 1'b0;
    end
`endif

    // ---------------------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef ALU_DIV_EN
                        div_q <= (bus.opcode == OpDiv);
`endif
                        if (!multi_in) begin
                            result_q <= sc_res;
                            zero_q   <= (sc_res == '0);
                            carry_q  <= sc_carry;
                            err_q    <= sc_err;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    cnt_q <= last_iter ? '0 : cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= calc_res;
                        zero_q   <= (calc_res == '0);
                        carry_q  <= 1'b0;
                        err_q    <= calc_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------------------
    // Handshake properties
    // ---------------------------------------------------------------------------------
    a_result_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.res_valid && !bus.res_ready) |=> (bus.res_valid && $stable(bus.result)
                                               && $stable({zero_q, carry_q, err_q})));

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.res_valid));

    a_cnt_idle_zero: assert property (@(posedge clk) disable iff (rst)
        (state_q != StCalc) |-> (cnt_q == '0));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table of single ops through a scoreboard, then
// hand-written sequences for result hold/backpressure and reset during CALC.
module tb_alu_exec_unit;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int NVEC = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_exec_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       zero;
        logic       carry;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[NVEC];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                input logic [7:0] res, input logic z, input logic c,
                                input logic e, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res;
        v.zero = z; v.carry = c; v.err = e; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Compare the DUT response against the oldest scoreboard entry.
    task automatic compare_head(input string name, input int lat);
        vec_t ev;
        if (exp_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        ev = exp_q.pop_front();
        chk({name, " result"}, 32'(bus.result), 32'(ev.res));
        chk({name, " flags zce"}, {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_err},
            {29'd0, ev.zero, ev.carry, ev.err});
        chk({name, " latency"}, 32'(lat), 32'(ev.lat));
    endtask

    // Drive one op with res_ready held high; latency counts the accept edge as edge 1.
    task automatic run_op(input vec_t v, input string name);
        bit ok;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.operands = {v.a, v.b};
        bus.opcode   = v.op;
        bus.res_ready = 1'b1;
        exp_q.push_back(v);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk({name, " accept timeout"}, 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
        if (!ok) begin
            chk({name, " res_valid timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        chk({name, " in_ready low in DONE"}, 32'(bus.in_ready), 32'd0);
        compare_head(name, lat);
        @(posedge clk);
        #1;
        chk({name, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
        chk({name, " res_valid after take"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.operands  = '0;
        bus.opcode    = '0;
        bus.res_ready = 1'b1;

        vecs[0]  = mk(4'h9, 4'h8, 3'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1);  // ADD carry
        vecs[1]  = mk(4'h3, 4'h5, 3'd1, 8'h0E, 1'b0, 1'b1, 1'b0, 1);  // SUB borrow
        vecs[2]  = mk(4'h6, 4'h6, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1);  // XOR zero
        vecs[3]  = mk(4'hC, 4'hA, 3'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1);  // AND
        vecs[4]  = mk(4'h5, 4'hA, 3'd3, 8'h0F, 1'b0, 1'b0, 1'b0, 1);  // OR
        vecs[5]  = mk(4'h1, 4'h2, 3'd5, 8'h21, 1'b0, 1'b0, 1'b0, 1);  // SWAP
        vecs[6]  = mk(4'hF, 4'h1, 3'd0, 8'h10, 1'b0, 1'b1, 1'b0, 1);  // ADD wrap
        vecs[7]  = mk(4'h0, 4'h0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1);  // SUB zero
        vecs[8]  = mk(4'hF, 4'hF, 3'd6, 8'hE1, 1'b0, 1'b0, 1'b0, 5);  // MUL max
        vecs[9]  = mk(4'h3, 4'h0, 3'd6, 8'h00, 1'b1, 1'b0, 1'b0, 5);  // MUL by 0
        vecs[10] = mk(4'h7, 4'h5, 3'd6, 8'h23, 1'b0, 1'b0, 1'b0, 5);  // MUL 35
`ifdef ALU_DIV_EN
        vecs[11] = mk(4'hD, 4'h4, 3'd7, 8'h13, 1'b0, 1'b0, 1'b0, 5);  // 13/4 = 3 r1
        vecs[12] = mk(4'h7, 4'h0, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 5);  // div by zero
        vecs[13] = mk(4'hF, 4'hF, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, 5);  // 15/15 = 1 r0
`else
        vecs[11] = mk(4'hD, 4'h4, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1, 1);  // illegal opcode
        vecs[12] = mk(4'h7, 4'h0, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        vecs[13] = mk(4'hF, 4'hF, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1, 1);
`endif

        // Reset for two cycles, then release.
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready during reset", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset result", 32'(bus.result), 32'd0);
        chk("reset flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_err}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // MUL with the consumer stalled; new stimulus on the bus must be ignored.
        @(negedge clk);
        chk("hold in_ready before accept", 32'(bus.in_ready), 32'd1);
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operands  = 8'hFF;
        bus.opcode    = 3'd6;
        exp_q.push_back(mk(4'hF, 4'hF, 3'd6, 8'hE1, 1'b0, 1'b0, 1'b0, 5));
        @(posedge clk);
        #1;
        bus.operands = 8'h11;
        bus.opcode   = 3'd0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("hold calc%0d res_valid", i), 32'(bus.res_valid), 32'd0);
            chk($sformatf("hold calc%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        chk("hold res_valid edge5", 32'(bus.res_valid), 32'd1);
        compare_head("hold mul", 5);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold stall%0d result", i), 32'(bus.result), 32'hE1);
            chk($sformatf("hold stall%0d res_valid", i), 32'(bus.res_valid), 32'd1);
            chk($sformatf("hold stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold released res_valid", 32'(bus.res_valid), 32'd0);
        chk("hold released in_ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted on the second CALC cycle of a MUL aborts it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.operands = 8'h75;
        bus.opcode   = 3'd6;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort res_valid", 32'(bus.res_valid), 32'd0);
        chk("abort in_ready in reset", 32'(bus.in_ready), 32'd0);
        chk("abort result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        chk("abort no stale res_valid", 32'(seen), 32'd0);
        chk("abort idle in_ready", 32'(bus.in_ready), 32'd1);
        run_op(mk(4'h1, 4'h1, 3'd0, 8'h02, 1'b0, 1'b0, 1'b0, 1), "post-abort add");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
